// File: rtl/timer_scheduler_pkg.sv
// Shared definitions for the timer scheduler: FSM state encoding and
// default sizing constants.
package timer_scheduler_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at ptr, wrapping modulo NREQ,
// and returns the first asserted request as a one-hot winner.
module rr_arbiter
  import timer_scheduler_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  // Priority scan ptr, ptr+1, ... ; first hit wins, later hits are masked by valid
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NREQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Timer scheduler: NREQ requesters share one down-counter, served one at a
// time in round-robin order. Each grant loads the winner's delay, counts it
// down to zero and pulses done to the owner.
// Optional feature: define TIMER_SCHED_ABORT_EN to add an abort input that
// cancels the active timer (no done pulse) from LOAD or RUN.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef TIMER_SCHED_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_delay,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [NREQ-1:0]  arb_winner;
  logic             arb_valid;
  logic [PTR_W-1:0] arb_idx;
  logic [WIDTH-1:0] delay_arr [NREQ];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
    return (w == PTR_W'(NREQ - 1)) ? '0 : w + PTR_W'(1);
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_delay
    assign delay_arr[g] = req_delay[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // One-hot winner to index, kept so the owner's delay slice and next pointer are cheap to form
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_winner[i]) arb_idx = PTR_W'(i);
    end
  end

  assign busy = (state != IDLE);

  // Scheduler FSM: arbitrate in IDLE, load delay, count down, pulse done, advance pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      done    <= '0;
      count   <= '0;
      ptr     <= '0;
      win_idx <= '0;
    end else begin
      done <= '0;
`ifdef TIMER_SCHED_ABORT_EN
      if (abort && (state == LOAD || state == RUN)) begin
        state <= IDLE;
        grant <= '0;
        count <= '0;
        ptr   <= next_ptr(win_idx);
      end else
`endif
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant   <= arb_winner;
            win_idx <= arb_idx;
            state   <= LOAD;
          end
        end
        LOAD: begin
          count <= delay_arr[win_idx];
          state <= RUN;
        end
        RUN: begin
          if (count == '0) begin
            done  <= grant;
            state <= DONE;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
        DONE: begin
          ptr   <= next_ptr(win_idx);
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed self-checking bench for timer_scheduler (NREQ=4, WIDTH=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_timer_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clock;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_delay;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;
`ifdef TIMER_SCHED_ABORT_EN
  logic                  abort;
`endif

  int checks   = 0;
  int failures = 0;

  timer_scheduler #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef TIMER_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .req       (req),
    .req_delay (req_delay),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_delay(input int i, input logic [WIDTH-1:0] v);
    req_delay[i*WIDTH +: WIDTH] = v;
  endtask

  // Leaves the bench on a falling edge with reset just released (cycle n0)
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req   = '0;
    req_delay = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Never more than one grant or done at a time
  always @(negedge clock) begin
    chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
    chk("done_onehot0", 64'($onehot0(done)), 64'd1);
  end

  initial begin
    reset = 1'b1;
    req = '0;
    req_delay = '0;
`ifdef TIMER_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    // reset state
    step(1);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;

    // single requester, delay 5: count 5..0, done at n8
    do_reset();
    req = 4'b0001;
    set_delay(0, 5);
    step(1);
    chk("t1_load_grant", grant, 4'b0001);
    chk("t1_load_busy", busy, 1);
    req = '0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("t1_run_count", count, 64'(5 - k));
      chk("t1_run_done", done, 0);
      chk("t1_run_grant", grant, 4'b0001);
    end
    step(1);
    chk("t1_done", done, 4'b0001);
    chk("t1_done_grant", grant, 4'b0001);
    step(1);
    chk("t1_idle_done", done, 0);
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_busy", busy, 0);

    // all four requesting with delay 0: done order 0,1,2,3,0, 4 cycles apart
    do_reset();
    req = 4'b1111;
    step(3);
    for (int k = 0; k < 5; k++) begin
      chk("t2_done_order", done, 64'(1 << (k % 4)));
      step(1);
      chk("t2_gap_done", done, 0);
      chk("t2_gap_grant", grant, 0);
      step(3);
    end
    req = '0;

    // delay 0 completes in 3 cycles; max delay loads without wrap
    do_reset();
    req = 4'b0100;
    set_delay(2, 0);
    step(1);
    chk("t3_grant", grant, 4'b0100);
    req = '0;
    step(1);
    chk("t3_count0", count, 0);
    step(1);
    chk("t3_done", done, 4'b0100);
    step(1);
    req = 4'b0100;
    set_delay(2, 32'hFFFF_FFFF);
    step(1);
    chk("t3_big_grant", grant, 4'b0100);
    req = '0;
    step(1);
    chk("t3_big_c0", count, 32'hFFFF_FFFF);
    step(1);
    chk("t3_big_c1", count, 32'hFFFF_FFFE);
    step(1);
    chk("t3_big_c2", count, 32'hFFFF_FFFD);
    chk("t3_big_done", done, 0);

    // reset during RUN at count 10, then requester 1 served
    do_reset();
    req = 4'b0001;
    set_delay(0, 12);
    step(1);
    req = '0;
    step(3);
    chk("t4_count10", count, 10);
    reset = 1'b1;
    #1;
    chk("t4_rst_grant", grant, 0);
    chk("t4_rst_count", count, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    step(1);
    chk("t4_rst_done2", done, 0);
    reset = 1'b0;
    req = 4'b0010;
    set_delay(1, 1);
    step(1);
    chk("t4_grant1", grant, 4'b0010);
    req = '0;
    step(1);
    chk("t4_c1", count, 1);
    step(2);
    chk("t4_done1", done, 4'b0010);

    // delay change mid-RUN is ignored
    do_reset();
    req = 4'b0001;
    set_delay(0, 3);
    step(1);
    req = '0;
    step(1);
    chk("t5_count3", count, 3);
    set_delay(0, 9);
    step(1);
    chk("t5_count2", count, 2);
    step(2);
    chk("t5_count0", count, 0);
    chk("t5_no_early_done", done, 0);
    step(1);
    chk("t5_done", done, 4'b0001);

    // held request is ranked last after its done
    do_reset();
    req = 4'b0011;
    step(1);
    chk("t6_g0", grant, 4'b0001);
    step(4);
    chk("t6_g1", grant, 4'b0010);
    step(4);
    chk("t6_g0_again", grant, 4'b0001);
    req = '0;
    step(2);
    chk("t6_done0", done, 4'b0001);

`ifdef TIMER_SCHED_ABORT_EN
    // abort at count 3: IDLE next cycle, no done, next grant to winner+1
    do_reset();
    req = 4'b0001;
    set_delay(0, 5);
    step(1);
    req = '0;
    step(3);
    chk("t7_count3", count, 3);
    abort = 1'b1;
    req = 4'b0011;
    step(1);
    abort = 1'b0;
    chk("t7_busy", busy, 0);
    chk("t7_grant", grant, 0);
    chk("t7_count", count, 0);
    chk("t7_done", done, 0);
    step(1);
    chk("t7_next_grant", grant, 4'b0010);
    req = '0;
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter SHALL be: NREQ, 4, number of requesters sharing the counter.
REQ-002 Parameter SHALL be: WIDTH, 32, counter and delay width in bits.
REQ-003 Port SHALL be: clock  input  1  single clock, all state on rising edge.
REQ-004 Port SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-005 Port SHALL be: req  input  NREQ  per-requester timer request level, bit i = requester i.
REQ-006 Port SHALL be: req_delay  input  NREQ*WIDTH  flattened delays, slice [i*WIDTH +: WIDTH] = requester i.
REQ-007 Port SHALL be: grant  output  NREQ  one-hot owner of the shared counter, zero when idle.
REQ-008 Port SHALL be: done  output  NREQ  one-cycle completion pulse to the owner.
REQ-009 Port SHALL be: busy  output  1  high whenever state is not IDLE.
REQ-010 Port SHALL be: count  output  WIDTH  remaining cycles of the active timer.

Function
REQ-011 FSM SHALL have states IDLE, LOAD, RUN, DONE; busy = (state != IDLE).
REQ-012 IDLE: if any req bit high, SHALL select one requester round-robin, starting at priority pointer, and go to LOAD; else stay IDLE.
REQ-013 Round-robin: search order ptr, ptr+1, ... mod NREQ; first high req wins.
REQ-014 LOAD: count SHALL load the winner's req_delay slice; next state RUN.
REQ-015 RUN: if count == 0 go DONE, else count decrements by 1 and stay RUN.
REQ-016 DONE: done[winner] SHALL be high for exactly this cycle; ptr = (winner+1) mod NREQ; next state IDLE.
REQ-017 grant SHALL be one-hot for the winner in LOAD, RUN and DONE, zero in IDLE.
REQ-018 Latency: req sampled in IDLE cycle t with delay D -> LOAD t+1, RUN t+2..t+2+D, done at t+3+D.
REQ-019 Delay 0 SHALL complete with a single RUN cycle; delay 2^WIDTH-1 SHALL complete without wrap; count never underflows.
REQ-020 req_delay and req changes after LOAD SHALL be ignored until DONE (except abort, REQ-026).
REQ-021 A requester holding req through its done SHALL be eligible again but ranked last behind others.
REQ-022 Simultaneous requests SHALL be served one at a time, never two grants at once.

Reset
REQ-023 On reset assertion, immediately: state IDLE, grant 0, done 0, busy 0, count 0, ptr 0.
REQ-024 Reset mid-RUN SHALL discard the active timer with no done pulse.
REQ-025 First arbitration after reset release SHALL favour requester 0.

Configuration
REQ-026 With TIMER_SCHED_ABORT_EN defined: extra 1-bit input abort; abort high in LOAD or RUN returns to IDLE next edge, no done, ptr = winner+1, count 0.
REQ-027 Without TIMER_SCHED_ABORT_EN: no abort port; timers always run to DONE.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (2-bit IDLE=0, LOAD=1, RUN=2, DONE=3) and default NREQ/WIDTH constants.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot winner, valid).

Verification
REQ-030 Single req[0], delay 5, sampled at t -> grant=0001 from t+1, done[0] at t+8, count 5,4,..,0.
REQ-031 req=1111 constant, delays 0 -> done pulses in order 0,1,2,3,0, each 4 cycles apart.
REQ-032 req[2] delay 0 -> done[2] exactly 3 cycles after sampling; delay 32'hFFFFFFFF loads without wrap (check first 3 decrements only).
REQ-033 reset asserted during RUN with count 10 -> grant, count, busy 0 same cycle, no done; req[1] afterward served first if req[0] low.
REQ-034 With TIMER_SCHED_ABORT_EN, abort in RUN at count 3 -> IDLE next cycle, no done, next grant goes to winner+1.
REQ-035 Change req_delay[0] mid-RUN -> count unaffected, done timing per original delay.
